// File: rtl/slink_bist_seq_pkg.sv
// -----------------------------------------------------------------------------
// slink_bist_seq_pkg
// Shared definitions for the S-Link BIST sequencer: the payload-mode code
// table (mode index -> 4-bit checker payload code), the number of swept
// modes, the mode-index width and the sequencer state encoding.
// -----------------------------------------------------------------------------
package slink_bist_seq_pkg;

  localparam int NUM_BIST_MODES = 5;
  // Wide enough to hold NUM_BIST_MODES itself, which marks "past the last mode".
  localparam int BIST_IDX_W     = $clog2(NUM_BIST_MODES + 1);

  // Payload codes understood by the RX BIST checker and the TX BIST generator.
  localparam logic [3:0] BIST_PAYLOAD_PRBS7  = 4'h1;
  localparam logic [3:0] BIST_PAYLOAD_PRBS15 = 4'h2;
  localparam logic [3:0] BIST_PAYLOAD_PRBS23 = 4'h3;
  localparam logic [3:0] BIST_PAYLOAD_PRBS31 = 4'h4;
  localparam logic [3:0] BIST_PAYLOAD_COUNT  = 4'h8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL,
    ST_CLR,
    ST_LOCK,
    ST_RUN,
    ST_SMP,
    ST_FAIL,
    ST_DIS,
    ST_FIN
  } seq_state_e;

  function automatic logic [3:0] bist_payload_code(input logic [BIST_IDX_W-1:0] idx);
    logic [3:0] code;
    case (idx)
      BIST_IDX_W'(0): code = BIST_PAYLOAD_PRBS7;
      BIST_IDX_W'(1): code = BIST_PAYLOAD_PRBS15;
      BIST_IDX_W'(2): code = BIST_PAYLOAD_PRBS23;
      BIST_IDX_W'(3): code = BIST_PAYLOAD_PRBS31;
      BIST_IDX_W'(4): code = BIST_PAYLOAD_COUNT;
      default:        code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/slink_bist_seq.sv
// -----------------------------------------------------------------------------
// slink_bist_seq
// Sequencer for the S-Link RX BIST checker (bist_en also mirrors to the TX
// generator). A start pulse sweeps every payload mode enabled in mode_mask:
// clear errors, enable, wait for lock, dwell pkt_count packets, sample the
// error count, disable. Per-mode fail bits and an overall pass are reported at
// the done pulse.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          run request pulse / abort level
//   mode_mask             modes to run (sampled at start)
//   pkt_count             packets per mode (0 behaves as 1)
//   err_thresh            a mode passes when errors <= err_thresh
//   lock_timeout          cycles allowed for lock (0 = wait forever)
//   rx_sop, bist_errors,
//   bist_locked, bist_unrec  checker status
//   bist_en, bist_reset,
//   bist_mode_payload     checker controls
//   busy, done, pass      run status (done is a 1-cycle pulse, pass valid at done)
//   fail_mask             per-mode failure bits
//   last_errors           error count captured for the most recent mode
// -----------------------------------------------------------------------------
module slink_bist_seq
  import slink_bist_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_MODES     = NUM_BIST_MODES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_MODES-1:0] mode_mask,
  input  logic [15:0]          pkt_count,
  input  logic [15:0]          err_thresh,
  input  logic [15:0]          lock_timeout,
  input  logic                 rx_sop,
  input  logic [15:0]          bist_errors,
  input  logic                 bist_locked,
  input  logic                 bist_unrec,
  output logic                 bist_en,
  output logic                 bist_reset,
  output logic [3:0]           bist_mode_payload,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_MODES-1:0] fail_mask,
  output logic [15:0]          last_errors
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [BIST_IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]            cnt_q, cnt_d;        // settle / lock-timeout / sop counter
  logic [NUM_MODES-1:0]   mask_q, mask_d;
  logic [15:0]            target_q, target_d;  // packets per mode, already max(pkt_count,1)
  logic [15:0]            thresh_q, thresh_d;
  logic [15:0]            tmo_q, tmo_d;
  logic                   aborted_q, aborted_d;

  logic                   bist_en_q, bist_en_d;
  logic                   bist_reset_q, bist_reset_d;
  logic [3:0]             payload_q, payload_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [NUM_MODES-1:0]   fail_mask_q, fail_mask_d;
  logic [15:0]            last_errors_q, last_errors_d;

  logic                   sel_found;
  logic [BIST_IDX_W-1:0]  sel_idx;

  // Lowest enabled mode at or above the current index; scanning downwards
  // lets the lowest match overwrite any higher one.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (mask_q[i] && (BIST_IDX_W'(i) >= idx_q)) begin
        sel_found = 1'b1;
        sel_idx   = BIST_IDX_W'(i);
      end
    end
  end

  // NOTE: every signal assigned here gets its default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    mask_d        = mask_q;
    target_d      = target_q;
    thresh_d      = thresh_q;
    tmo_d         = tmo_q;
    aborted_d     = aborted_q;
    bist_en_d     = bist_en_q;
    bist_reset_d  = bist_reset_q;
    payload_d     = payload_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    fail_mask_d   = fail_mask_q;
    last_errors_d = last_errors_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_mask != '0) begin
            mask_d      = mode_mask;
            target_d    = (pkt_count == 16'd0) ? 16'd1 : pkt_count;
            thresh_d    = err_thresh;
            tmo_d       = lock_timeout;
            fail_mask_d = '0;
            aborted_d   = 1'b0;
            idx_d       = '0;
            busy_d      = 1'b1;
            pass_d      = 1'b0;
            state_d     = ST_SEL;
          end else begin
            // Empty mask: report an immediate failed run without going busy.
            done_d = 1'b1;
            pass_d = 1'b0;
          end
        end
      end

      ST_SEL: begin
        if (sel_found) begin
          idx_d        = sel_idx;
          payload_d    = bist_payload_code(sel_idx);
          bist_reset_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_CLR;
        end else begin
          state_d = ST_FIN;
        end
      end

      ST_CLR: begin
        if (cnt_q == SETTLE_LAST) begin
          bist_reset_d = 1'b0;
          bist_en_d    = 1'b1;
          cnt_d        = '0;
          state_d      = ST_LOCK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_LOCK: begin
        if (bist_unrec) begin
          state_d = ST_FAIL;
        end else if (bist_locked) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (tmo_q != 16'd0) begin
          if (cnt_q == tmo_q) state_d = ST_FAIL;
          else                cnt_d   = cnt_q + 16'd1;
        end
      end

      ST_RUN: begin
        // Unrecoverable or lost lock wins over a coincident final sop.
        if (bist_unrec || !bist_locked) begin
          state_d = ST_FAIL;
        end else if (rx_sop) begin
          if (cnt_q == target_q - 16'd1) begin
            cnt_d   = '0;
            state_d = ST_SMP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_SMP: begin
        // Dwell so the checker's last error update has crossed its sync.
        if (cnt_q == SETTLE_LAST) begin
          last_errors_d = bist_errors;
          if (bist_errors > thresh_q) fail_mask_d[idx_q] = 1'b1;
          bist_en_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_DIS;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_FAIL: begin
        fail_mask_d[idx_q] = 1'b1;
        last_errors_d      = bist_errors;
        bist_en_d          = 1'b0;
        cnt_d              = '0;
        state_d            = ST_DIS;
      end

      ST_DIS: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (aborted_q || abort) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + BIST_IDX_W'(1);
            state_d = ST_SEL;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_mask_q == '0) && !aborted_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides the per-state decision everywhere except IDLE and FIN.
    // DIS keeps counting so the checker still gets its full disable time.
    if (abort && (state_q inside {ST_SEL, ST_CLR, ST_LOCK, ST_RUN, ST_SMP, ST_FAIL, ST_DIS})) begin
      aborted_d = 1'b1;
      if (state_q != ST_DIS) begin
        bist_en_d    = 1'b0;
        bist_reset_d = 1'b0;
        cnt_d        = '0;
        state_d      = ST_DIS;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge; the reset is asynchronous,
  // so outputs clear as soon as reset rises, not at the next clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      target_q      <= '0;
      thresh_q      <= '0;
      tmo_q         <= '0;
      aborted_q     <= 1'b0;
      bist_en_q     <= 1'b0;
      bist_reset_q  <= 1'b0;
      payload_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_mask_q   <= '0;
      last_errors_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      target_q      <= target_d;
      thresh_q      <= thresh_d;
      tmo_q         <= tmo_d;
      aborted_q     <= aborted_d;
      bist_en_q     <= bist_en_d;
      bist_reset_q  <= bist_reset_d;
      payload_q     <= payload_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_mask_q   <= fail_mask_d;
      last_errors_q <= last_errors_d;
    end
  end

  assign bist_en           = bist_en_q;
  assign bist_reset        = bist_reset_q;
  assign bist_mode_payload = payload_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign fail_mask         = fail_mask_q;
  assign last_errors       = last_errors_q;

endmodule

// File: tb/tb_slink_bist_seq.sv
// -----------------------------------------------------------------------------
// tb_slink_bist_seq
// Bench for slink_bist_seq. A small link emulator answers bist_en with lock,
// sop strobes, error counts and optional unrecoverable events per mode; the
// expected fail_mask / pass / last_errors of each run and the handshake
// timing are derived from the per-mode scenario.
// -----------------------------------------------------------------------------
module tb_slink_bist_seq;

  localparam int SETTLE = 4;
  localparam int BUDGET = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [4:0]  mode_mask;
  logic [15:0] pkt_count, err_thresh, lock_timeout;
  logic        rx_sop;
  logic [15:0] bist_errors;
  logic        bist_locked, bist_unrec;
  logic        bist_en, bist_reset;
  logic [3:0]  bist_mode_payload;
  logic        busy, done, pass;
  logic [4:0]  fail_mask;
  logic [15:0] last_errors;

  slink_bist_seq #(.SETTLE_CYCLES(SETTLE), .NUM_MODES(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mode_mask(mode_mask), .pkt_count(pkt_count), .err_thresh(err_thresh),
    .lock_timeout(lock_timeout), .rx_sop(rx_sop), .bist_errors(bist_errors),
    .bist_locked(bist_locked), .bist_unrec(bist_unrec),
    .bist_en(bist_en), .bist_reset(bist_reset), .bist_mode_payload(bist_mode_payload),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask), .last_errors(last_errors)
  );

  always #5 clk = ~clk;

  // Per-mode link scenario: lock delay in cycles after enable (-1 = never),
  // sop index at which unrec fires (-1 = never), error count reported.
  int          lock_dly [5];
  int          unrec_at [5];
  logic [15:0] errs     [5];
  logic [15:0] exp_last;
  logic [4:0]  last_fm;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mode_of(input logic [3:0] p);
    case (p)
      4'h1: return 0;
      4'h2: return 1;
      4'h3: return 2;
      4'h4: return 3;
      4'h8: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic set_clean();
    for (int i = 0; i < 5; i++) begin
      lock_dly[i] = $urandom_range(0, 3);
      unrec_at[i] = -1;
      errs[i]     = 16'd0;
    end
  endtask

  // ab_kind: 0 none, 1 abort in LOCK of ab_mode, 2 abort in CLR of ab_mode.
  task automatic run_one(input string tag, input logic [4:0] mask, input logic [15:0] pkt,
                         input logic [15:0] thr, input logic [15:0] tmo,
                         input int ab_kind, input int ab_mode, input bit mid_start);
    int          exp_q[$];
    logic [4:0]  exp_fm;
    logic [15:0] exp_le;
    bit          exp_pass;
    int          target, cyc, cur, en_age, cnt_sops, rst_w, fall_cyc;
    int          final_cyc, unrec_cyc, abort_cyc, exp_m, extra;
    bit          done_seen, en_prev, rst_prev, lk, lk_prev, unrec_on, ab_done, had_fall;

    // Reference outcome of the run from the scenario.
    target = (pkt == 16'd0) ? 1 : int'(pkt);
    exp_fm = 5'd0;
    exp_le = exp_last;
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) begin
        if (ab_kind != 0 && i == ab_mode) begin
          if (ab_kind == 1) exp_q.push_back(i);
          break;
        end
        exp_q.push_back(i);
        exp_le = errs[i];
        if (unrec_at[i] >= 0 || (lock_dly[i] < 0 && tmo != 16'd0) || errs[i] > thr)
          exp_fm[i] = 1'b1;
      end
    end
    if (mask == 5'd0) exp_fm = last_fm;
    exp_pass = (mask != 5'd0) && (ab_kind == 0) && (exp_fm == 5'd0);

    cur = -1; en_age = 0; cnt_sops = 0; rst_w = 0; fall_cyc = 0;
    final_cyc = -1; unrec_cyc = 0; abort_cyc = 0;
    done_seen = 0; en_prev = 0; rst_prev = 0; lk = 0; lk_prev = 0;
    unrec_on = 0; ab_done = 0; had_fall = 0;

    @(negedge clk);
    mode_mask = mask; pkt_count = pkt; err_thresh = thr; lock_timeout = tmo;
    bist_locked = 0; bist_unrec = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the configuration: the run must use the values latched at start.
    mode_mask = 5'h1F; pkt_count = 16'($urandom); err_thresh = 16'($urandom);
    lock_timeout = 16'($urandom);
    check({tag, ":busy_at_start"}, busy, (mask != 5'd0));
    cyc = 1;

    while (!done_seen) begin
      if (cyc > BUDGET) begin
        check({tag, ":done_within_budget"}, 0, 1);
        break;
      end
      if (done) begin
        done_seen = 1'b1;
        check({tag, ":pass"}, pass, exp_pass);
        check({tag, ":fail_mask"}, fail_mask, exp_fm);
        check({tag, ":last_errors"}, last_errors, exp_le);
        check({tag, ":busy_at_done"}, busy, 0);
        check({tag, ":modes_left"}, exp_q.size(), 0);
      end else begin
        // ---- observe ----
        if (ab_kind == 2 && ab_done && cyc == abort_cyc + 1)
          check({tag, ":abort_clr_drop"}, {bist_reset, bist_en}, 2'b00);
        if (bist_reset && !rst_prev) rst_w = 0;
        if (bist_reset) rst_w++;
        rst_prev = bist_reset;
        if (bist_en && !en_prev) begin
          cur   = mode_of(bist_mode_payload);
          exp_m = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          check({tag, ":mode_order"}, cur, exp_m);
          check({tag, ":reset_width"}, rst_w, SETTLE);
          if (had_fall) check({tag, ":mode_gap"}, cyc - fall_cyc, 2 * SETTLE + 1);
          en_age = 0; cnt_sops = 0; lk = 0; lk_prev = 0; unrec_on = 0; final_cyc = -1;
        end
        if (!bist_en && en_prev) begin
          if (ab_kind == 1 && ab_done)  check({tag, ":abort_to_dis"}, cyc, abort_cyc + 1);
          else if (unrec_on)            check({tag, ":unrec_to_dis"}, cyc, unrec_cyc + 2);
          else if (final_cyc >= 0)      check({tag, ":sop_to_dis"}, cyc, final_cyc + SETTLE + 1);
          else                          check({tag, ":lock_timeout"}, en_age, int'(tmo) + 2);
          had_fall = 1'b1;
          fall_cyc = cyc;
        end
        en_prev = bist_en;

        // ---- drive the link for this cycle ----
        start  = mid_start && (cyc == 7);
        abort  = 1'b0;
        rx_sop = 1'($urandom_range(0, 1));
        if (bist_en && cur >= 0) begin
          en_age++;
          lk_prev = lk;
          lk = (lock_dly[cur] >= 0) && (en_age > lock_dly[cur]);
          bist_locked = lk;
          bist_errors = errs[cur];
          // A sop counts only once the sequencer has seen lock (RUN).
          if (lk_prev && !unrec_on && final_cyc < 0) begin
            if (unrec_at[cur] >= 0 && cnt_sops == unrec_at[cur]) begin
              unrec_on  = 1'b1;
              unrec_cyc = cyc;
            end else if (rx_sop) begin
              cnt_sops++;
              if (cnt_sops == target) final_cyc = cyc;
            end
          end
          bist_unrec = unrec_on;
          if (ab_kind == 1 && !ab_done && cur == ab_mode && en_age == 3) begin
            abort = 1'b1; abort_cyc = cyc; ab_done = 1'b1;
          end
        end else begin
          bist_locked = 1'b0;
          bist_unrec  = 1'b0;
          bist_errors = 16'($urandom);
        end
        if (ab_kind == 2 && !ab_done && bist_reset && mode_of(bist_mode_payload) == ab_mode) begin
          abort = 1'b1; abort_cyc = cyc; ab_done = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end

    start = 0; abort = 0; bist_locked = 0; bist_unrec = 0; rx_sop = 0;
    @(negedge clk);
    check({tag, ":done_pulse_width"}, done, 0);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check({tag, ":quiet_after_done"}, extra, 0);
    if (mask != 5'd0) begin
      exp_last = exp_le;
      last_fm  = exp_fm;
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; mode_mask = 0; pkt_count = 0; err_thresh = 0;
    lock_timeout = 0; rx_sop = 0; bist_errors = 0; bist_locked = 0; bist_unrec = 0;
    exp_last = 16'd0; last_fm = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bist_en, bist_reset, bist_mode_payload, busy, done, pass,
                            fail_mask, last_errors}, 0);
    reset = 1'b0;

    set_clean();
    run_one("t1_single", 5'b00001, 16'd8, 16'd0, 16'd0, 0, 0, 0);

    set_clean(); errs[2] = 16'd3;
    run_one("t2_errs", 5'b10101, 16'd4, 16'd0, 16'd20, 0, 0, 0);

    set_clean(); lock_dly[0] = -1; errs[0] = 16'd9;
    run_one("t3_timeout", 5'b00011, 16'd3, 16'd0, 16'd50, 0, 0, 0);

    set_clean(); unrec_at[1] = 2; errs[1] = 16'd4;
    run_one("t4_unrec", 5'b00110, 16'd5, 16'd10, 16'd30, 0, 0, 0);

    set_clean(); errs[0] = 16'd7; lock_dly[1] = -1;
    run_one("t5_abort_lock", 5'b00011, 16'd2, 16'd10, 16'd0, 1, 1, 1);

    set_clean(); errs[1] = 16'd2;
    run_one("t5_abort_clr", 5'b11010, 16'd2, 16'd5, 16'd10, 2, 3, 0);

    run_one("t7_mask0", 5'b00000, 16'd1, 16'd0, 16'd0, 0, 0, 0);

    set_clean(); errs[0] = 16'hFFFF; errs[1] = 16'hFFFF;
    run_one("t8_sat_pass", 5'b00011, 16'd0, 16'hFFFF, 16'd0, 0, 0, 0);
    run_one("t8_sat_fail", 5'b00011, 16'd1, 16'hFFFE, 16'd0, 0, 0, 0);

    set_clean(); errs[0] = 16'd5; errs[1] = 16'd6;
    run_one("t8_thresh_edge", 5'b00011, 16'd2, 16'd5, 16'd12, 0, 0, 0);

    // Asynchronous reset in the middle of RUN.
    set_clean();
    @(negedge clk);
    mode_mask = 5'b00001; pkt_count = 16'd100; err_thresh = 16'd0; lock_timeout = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bist_locked = 1'b1; rx_sop = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_busy_before_reset", {busy, bist_en}, 2'b11);
    #2 reset = 1'b1;
    #1 check("t6_outputs_async_clear", {bist_en, bist_reset, bist_mode_payload, busy, done,
                                        pass, fail_mask, last_errors}, 0);
    @(negedge clk);
    reset = 1'b0; bist_locked = 1'b0;
    exp_last = 16'd0; last_fm = 5'd0;
    set_clean(); errs[3] = 16'd1;
    run_one("t6_after_reset", 5'b01001, 16'd3, 16'd1, 16'd15, 0, 0, 0);

    // Randomized sweeps.
    for (int r = 0; r < 25; r++) begin
      logic [4:0]  m;
      logic [15:0] p, t, to;
      int          tgt, k;
      m   = 5'($urandom_range(1, 31));
      p   = 16'($urandom_range(0, 6));
      tgt = (p == 16'd0) ? 1 : int'(p);
      k   = $urandom_range(0, 2);
      t   = (k == 0) ? 16'd0 : (k == 1) ? 16'($urandom_range(1, 20)) : 16'hFFFF;
      to  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(6, 40));
      for (int i = 0; i < 5; i++) begin
        int sc;
        sc          = $urandom_range(0, 5);
        lock_dly[i] = $urandom_range(0, 5);
        unrec_at[i] = -1;
        if (sc == 0 && to != 16'd0) lock_dly[i] = -1;
        else if (sc == 1)           unrec_at[i] = $urandom_range(0, tgt - 1);
        case ($urandom_range(0, 4))
          0:       errs[i] = 16'd0;
          1:       errs[i] = t;
          2:       errs[i] = t + 16'd1;
          3:       errs[i] = 16'hFFFF;
          default: errs[i] = 16'($urandom);
        endcase
      end
      run_one($sformatf("rnd%0d", r), m, p, t, to, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
